// File: rtl/debug_pkg.sv
// Shared constants and FSM encoding for the debug snapshot block.
package debug_pkg;

    localparam int DBG_ADDR_W  = 5;
    localparam int DBG_DATA_W  = 32;
    localparam int DBG_ENTRIES = 32;
    localparam int DBG_CNT_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2
    } snap_state_e;

endpackage

// File: rtl/debug_snap_ram.sv
// Snapshot buffer: one write port plus one registered read port.
// A read and a write to the same index in the same cycle return the old word.
module debug_snap_ram
    import debug_pkg::*;
#(
    parameter int ADDR_W = DBG_ADDR_W,
    parameter int DATA_W = DBG_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // NOTE: the array has no reset so it maps onto RAM; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/debug_snapshot.sv
// Sweeps every debug address, lets the mux settle, and captures each word into
// a buffer the display side can read coherently; forwards live_addr while idle.
module debug_snapshot
    import debug_pkg::*;
#(
    parameter int ADDR_W = DBG_ADDR_W,
    parameter int DATA_W = DBG_DATA_W,
    parameter int SETTLE = 1            // legal range 1..15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              snap_req,
    input  logic [ADDR_W-1:0] live_addr,
    output logic [ADDR_W-1:0] debug_addr,
    input  logic [DATA_W-1:0] test_signal,
    output logic              busy,
    output logic              done,
    output logic              valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W-1:0]    LAST_IDX    = '1;
    localparam logic [DBG_CNT_W-1:0] SETTLE_INIT = DBG_CNT_W'(SETTLE - 1);

    snap_state_e          state_q;
    logic [ADDR_W-1:0]    idx_q;
    logic [DBG_CNT_W-1:0] cnt_q;
    logic [ADDR_W-1:0]    debug_addr_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 valid_q;
    logic                 we_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            debug_addr_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    debug_addr_q <= live_addr;
                    if (snap_req) begin
                        idx_q        <= '0;
                        debug_addr_q <= '0;
                        cnt_q        <= SETTLE_INIT;
                        valid_q      <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q <= S_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_CAPTURE: begin
                    if (idx_q == LAST_IDX) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        idx_q        <= idx_q + ADDR_W'(1);
                        debug_addr_q <= idx_q + ADDR_W'(1);
                        cnt_q        <= SETTLE_INIT;
                        state_q      <= S_SETTLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Capture is suppressed in a reset cycle so an aborted sweep leaves that entry untouched.
    assign we_d = (state_q == S_CAPTURE) && !rst;

    debug_snap_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .we_i      (we_d),
        .wr_addr_i (idx_q),
        .wr_data_i (test_signal),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    assign debug_addr = debug_addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign valid      = valid_q;

endmodule

// File: tb/tb_debug_snapshot.sv
// Directed bench for debug_snapshot: reset, live forwarding, sweep timing,
// held request, mid-sweep reset, reset/request priority and a SETTLE=3 sweep.
module tb_debug_snapshot;
    import debug_pkg::*;

    localparam int AW = DBG_ADDR_W;
    localparam int DW = DBG_DATA_W;
    localparam logic [DW-1:0] BASE_A = 32'hA5A5_0000;
    localparam logic [DW-1:0] BASE_B = 32'h5A5A_0000;
    localparam logic [DW-1:0] BASE_C = 32'hC3C3_0000;

    logic          clk = 1'b0;
    logic          rst, snap_req, snap_req3;
    logic [AW-1:0] live_addr, rd_addr, debug_addr, debug_addr3;
    logic [DW-1:0] base, test_signal, test_signal3, rd_data, rd_data3;
    logic          busy, done, valid, busy3, done3, valid3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Mux model: each address returns a recognisable word.
    assign test_signal  = base   | DW'(debug_addr);
    assign test_signal3 = BASE_C | DW'(debug_addr3);

    debug_snapshot #(.SETTLE(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .snap_req    (snap_req),
        .live_addr   (live_addr),
        .debug_addr  (debug_addr),
        .test_signal (test_signal),
        .busy        (busy),
        .done        (done),
        .valid       (valid),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    debug_snapshot #(.SETTLE(3)) dut3 (
        .clk         (clk),
        .rst         (rst),
        .snap_req    (snap_req3),
        .live_addr   (live_addr),
        .debug_addr  (debug_addr3),
        .test_signal (test_signal3),
        .busy        (busy3),
        .done        (done3),
        .valid       (valid3),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input bit use3, input int exp_lat);
        int n = 0;
        while (!(use3 ? done3 : done) && n < 300) begin
            step();
            n++;
        end
        check(tag, 32'(n), 32'(exp_lat));
    endtask

    initial begin
        rst       = 1'b1;
        snap_req  = 1'b0;
        snap_req3 = 1'b0;
        live_addr = '0;
        rd_addr   = '0;
        base      = BASE_A;

        // 1. reset state
        repeat (3) step();
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_done",  32'(done),       32'd0);
        check("rst_valid", 32'(valid),      32'd0);
        check("rst_daddr", 32'(debug_addr), 32'd0);
        check("rst_rdata", rd_data,         32'd0);
        rst = 1'b0;

        // 2. live forwarding while idle
        live_addr = 5'd17;
        step();
        check("live_17", 32'(debug_addr), 32'd17);
        check("live_busy", 32'(busy), 32'd0);
        live_addr = 5'd3;
        step();
        check("live_3", 32'(debug_addr), 32'd3);

        // 3. single-pulse sweep, SETTLE=1
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        check("s3_busy", 32'(busy), 32'd1);
        check("s3_daddr0", 32'(debug_addr), 32'd0);
        wait_done("s3_latency", 1'b0, 64);
        check("s3_valid", 32'(valid), 32'd1);
        check("s3_busy_end", 32'(busy), 32'd0);
        check("s3_daddr_hold", 32'(debug_addr), 32'd31);
        step();
        check("s3_done_pulse", 32'(done), 32'd0);
        check("s3_daddr_live", 32'(debug_addr), 32'd3);
        for (int k = 0; k < 32; k++) begin
            rd_addr = AW'(k);
            step();
            check($sformatf("s3_rd%0d", k), rd_data, BASE_A + 32'(k));
        end

        // 4. level-high request: one done, immediate restart
        snap_req = 1'b1;
        step();
        wait_done("s4_latency", 1'b0, 64);
        check("s4_valid", 32'(valid), 32'd1);
        step();
        check("s4_done_once", 32'(done), 32'd0);
        check("s4_restart_busy", 32'(busy), 32'd1);
        check("s4_restart_valid", 32'(valid), 32'd0);
        check("s4_restart_daddr", 32'(debug_addr), 32'd0);
        snap_req = 1'b0;
        wait_done("s4_latency2", 1'b0, 64);
        step();

        // 5. reset while idx=10 (CAPTURE of entry 10 is the next edge)
        base     = BASE_B;
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        repeat (21) step();
        check("s5_daddr10", 32'(debug_addr), 32'd10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("s5_busy", 32'(busy), 32'd0);
        check("s5_valid", 32'(valid), 32'd0);
        check("s5_daddr", 32'(debug_addr), 32'd0);
        check("s5_done", 32'(done), 32'd0);
        for (int k = 0; k < 32; k++) begin
            rd_addr = AW'(k);
            step();
            check($sformatf("s5_rd%0d", k), rd_data, (k < 10 ? BASE_B : BASE_A) + 32'(k));
        end

        // 6. reset beats a simultaneous request
        rst      = 1'b1;
        snap_req = 1'b1;
        step();
        check("s6_busy_rst", 32'(busy), 32'd0);
        rst      = 1'b0;
        snap_req = 1'b0;
        step();
        check("s6_busy_after", 32'(busy), 32'd0);
        check("s6_daddr_live", 32'(debug_addr), 32'd3);

        // 6b. SETTLE=3 sweep
        snap_req3 = 1'b1;
        step();
        snap_req3 = 1'b0;
        check("s6_busy3", 32'(busy3), 32'd1);
        wait_done("s6_latency3", 1'b1, 128);
        check("s6_valid3", 32'(valid3), 32'd1);
        step();
        check("s6_done3_pulse", 32'(done3), 32'd0);
        for (int k = 0; k < 32; k += 5) begin
            rd_addr = AW'(k);
            step();
            check($sformatf("s6_rd3_%0d", k), rd_data3, BASE_C + 32'(k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
